// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port data memory.
//   Port 0 is the CPU load/store path. Port 1 is the loader/debug DMA path.
//   Ownership is registered, so the grant for a cycle is decided at the
//   preceding edge. A starvation guard hands the memory to port 1 after it
//   has waited MAX_WAIT consecutive cycles behind port 0.
// Ports:
//   clk_i, reset_i          clock (rising edge), asynchronous active-high reset
//   reqN_i, weN_i           port N request (held until served) and write enable
//   addrN_i, wdataN_i       port N byte address and write data
//   gntN_o                  port N owns the memory this cycle (registered)
//   rvalidN_o               mem_rdata_i carries port N read data this cycle
//   rdataN_o                read data fanned out to port N
//   mem_addr_o, mem_wdata_o owner's address and write data, else 0
//   mem_we_o                memory write enable
//   mem_rdata_i             combinational read data from the memory
//   err_o                   1-cycle pulse after an owner's illegal access
module dmem_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned WORDS    = 64,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              gnt0_o,
    output logic              rvalid0_o,
    output logic [DATA_W-1:0] rdata0_o,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt1_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] AddrLimit = ADDR_W'(4 * WORDS);
    localparam logic [3:0]        WaitLast  = 4'(MAX_WAIT - 1);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        gnt0_q, gnt1_q;
    logic        err_q, err_d;

    logic              own_req, own_we, legal;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        unique case (state_q)
            StIdle: begin
                if (req0_i)      state_d = StOwn0;
                else if (req1_i) state_d = StOwn1;
            end
            StOwn0: begin
                if (!req0_i)                                 state_d = req1_i ? StOwn1 : StIdle;
                else if (req1_i && wait_cnt_q == WaitLast)   state_d = StOwn1;
            end
            StOwn1: begin
                // Port 1 keeps the memory while it requests; loader bursts are bounded.
                if (!req1_i) state_d = req0_i ? StOwn0 : StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Count only while port 1 keeps waiting behind port 0; any other case clears.
        if (state_q == StOwn0 && req1_i && state_d == StOwn0) begin
            wait_cnt_d = (wait_cnt_q == WaitLast) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end
    end

    // Owner mux; an idle memory sees zeros.
    always_comb begin
        own_req   = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        if (gnt0_q) begin
            own_req   = req0_i;
            own_we    = we0_i;
            own_addr  = addr0_i;
            own_wdata = wdata0_i;
        end else if (gnt1_q) begin
            own_req   = req1_i;
            own_we    = we1_i;
            own_addr  = addr1_i;
            own_wdata = wdata1_i;
        end
        legal = (own_addr[1:0] == 2'b00) && (own_addr < AddrLimit);
        err_d = own_req & ~legal;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            gnt0_q     <= (state_d == StOwn0);
            gnt1_q     <= (state_d == StOwn1);
            err_q      <= err_d;
        end
    end

    assign gnt0_o      = gnt0_q;
    assign gnt1_o      = gnt1_q;
    assign err_o       = err_q;
    assign mem_addr_o  = own_addr;
    assign mem_wdata_o = own_wdata;
    assign mem_we_o    = own_we & own_req & legal;
    assign rvalid0_o   = gnt0_q & req0_i & ~we0_i & legal;
    assign rvalid1_o   = gnt1_q & req1_i & ~we1_i & legal;
    assign rdata0_o    = mem_rdata_i;
    assign rdata1_o    = mem_rdata_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural owner/starvation model and a
// shadow copy of the memory contents.
module tb_dmem_arbiter;

    localparam int Words   = 64;
    localparam int MaxWait = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, err;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    bit [31:0] ram     [Words];
    bit [31:0] exp_ram [Words];

    int checks = 0;
    int errors = 0;

    // Reference model: current owner (0 none, 1 port 0, 2 port 1), how long
    // port 1 has waited behind port 0, and the expected err output.
    int own;
    int starve;
    bit exp_err;

    dmem_arbiter #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .WORDS   (Words),
        .MAX_WAIT(MaxWait)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .req0_i     (req0),
        .we0_i      (we0),
        .addr0_i    (addr0),
        .wdata0_i   (wdata0),
        .gnt0_o     (gnt0),
        .rvalid0_o  (rvalid0),
        .rdata0_o   (rdata0),
        .req1_i     (req1),
        .we1_i      (we1),
        .addr1_i    (addr1),
        .wdata1_i   (wdata1),
        .gnt1_o     (gnt1),
        .rvalid1_o  (rvalid1),
        .rdata1_o   (rdata1),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_we_o   (mem_we),
        .mem_rdata_i(mem_rdata),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    // The memory the arbiter fronts.
    always @(posedge clk) if (mem_we === 1'b1) ram[mem_addr[7:2]] <= mem_wdata;
    assign mem_rdata = ram[mem_addr[7:2]];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own     = 0;
        starve  = 0;
        exp_err = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        int k = int'($urandom_range(9));
        if (k == 0) return 32'(($urandom_range(63) << 2) | $urandom_range(3, 1));
        if (k == 1) return 32'(32'h100 + ($urandom_range(255) << 2));
        return 32'($urandom_range(63) << 2);
    endfunction

    // One clock cycle: drive inputs at edge+1, check at edge+3, advance model at next edge.
    task automatic cycle(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
        bit          orq, owe, ok, ewe, erv0, erv1;
        logic [31:0] oa, od;
        int          own_n;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #2;
        orq = 0; owe = 0; oa = 0; od = 0;
        if (own == 1) begin orq = r0; owe = w0; oa = a0; od = d0; end
        else if (own == 2) begin orq = r1; owe = w1; oa = a1; od = d1; end
        ok   = (oa % 4 == 0) && (oa < 4 * Words);
        ewe  = orq && owe && ok;
        erv0 = (own == 1) && r0 && !w0 && ok;
        erv1 = (own == 2) && r1 && !w1 && ok;
        check_eq("gnt0", 32'(gnt0), 32'(own == 1));
        check_eq("gnt1", 32'(gnt1), 32'(own == 2));
        check_eq("err", 32'(err), 32'(exp_err));
        check_eq("mem_we", 32'(mem_we), 32'(ewe));
        check_eq("mem_addr", mem_addr, oa);
        check_eq("mem_wdata", mem_wdata, od);
        check_eq("rvalid0", 32'(rvalid0), 32'(erv0));
        check_eq("rvalid1", 32'(rvalid1), 32'(erv1));
        if (erv0) check_eq("rdata0", rdata0, exp_ram[oa[7:2]]);
        if (erv1) check_eq("rdata1", rdata1, exp_ram[oa[7:2]]);

        own_n = own;
        if (own == 0) begin
            own_n = r0 ? 1 : (r1 ? 2 : 0);
        end else if (own == 1) begin
            if (!r0)                             own_n = r1 ? 2 : 0;
            else if (r1 && starve == MaxWait - 1) own_n = 2;
        end else begin
            if (!r1) own_n = r0 ? 1 : 0;
        end
        if (own == 1 && own_n == 1 && r1) starve = (starve + 1 > MaxWait - 1) ? MaxWait - 1 : starve + 1;
        else starve = 0;
        exp_err = (own != 0) && orq && !ok;
        if (ewe) exp_ram[oa[7:2]] = od;
        own = own_n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit r0 = 0;
        bit r1 = 0;
        int n;

        // T1: reset held with both requesting.
        reset = 1; req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        model_reset();
        #1;
        check_eq("t1_gnt0", 32'(gnt0), 0);
        check_eq("t1_gnt1", 32'(gnt1), 0);
        check_eq("t1_we", 32'(mem_we), 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t1_gnt0_held", 32'(gnt0), 0);
        check_eq("t1_err", 32'(err), 0);
        reset = 0;
        cycle(1, 0, 0, 0, 1, 0, 0, 0);
        check_eq("t1_gnt0_after", 32'(gnt0), 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);

        // T2: port 0 write then read back.
        cycle(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        check_eq("t2_ram4", ram[4], 32'hDEADBEEF);
        cycle(1, 0, 32'h10, 0, 0, 0, 0, 0);

        // T3: handoff without an idle bubble.
        repeat (3) cycle(1, 0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        check_eq("t3_handoff", 32'(gnt1), 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // T4: starvation guard.
        cycle(1, 0, 0, 0, 1, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 20 && gnt1 !== 1'b1; i++) begin
            if (gnt0 === 1'b1) n++;
            cycle(1, 0, 0, 0, 1, 0, 0, 0);
        end
        check_eq("t4_own0_cycles", 32'(n), 32'(MaxWait));
        check_eq("t4_gnt1", 32'(gnt1), 1);
        cycle(1, 0, 0, 0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t4_gnt0_back", 32'(gnt0), 1);

        // T5: misaligned then out-of-range writes by the owner.
        cycle(1, 1, 32'h102, 32'h12345678, 0, 0, 0, 0);
        check_eq("t5_err_a", 32'(err), 1);
        cycle(1, 1, 32'h100, 32'h12345678, 0, 0, 0, 0);
        check_eq("t5_err_b", 32'(err), 1);
        check_eq("t5_ram0", ram[0], exp_ram[0]);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) == 0) r0 = !r0;
            if ($urandom_range(3) == 0) r1 = !r1;
            cycle(r0, 1'($urandom_range(1)), rand_addr(), $urandom,
                  r1, 1'($urandom_range(1)), rand_addr(), $urandom);
        end

        // T6: asynchronous reset in the middle of a port 1 write.
        for (int i = 0; i < 6 && own != 2; i++) cycle(0, 0, 0, 0, 1, 0, 0, 0);
        check_eq("t6_own1", 32'(gnt1), 1);
        req0 = 0; we0 = 0;
        req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'hCAFEF00D;
        #2;
        check_eq("t6_we_before", 32'(mem_we), 1);
        reset = 1;
        #1;
        check_eq("t6_gnt1", 32'(gnt1), 0);
        check_eq("t6_we", 32'(mem_we), 0);
        check_eq("t6_err", 32'(err), 0);
        @(posedge clk);
        #1;
        check_eq("t6_ram8", ram[8], exp_ram[8]);
        model_reset();
        reset = 0;
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
